// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the 16-by-8 signed divider.
//   state_e         : controller states (IDLE, CALC, FIX, DONE)
//   DIV_W / DVD_W   : divisor / dividend widths
//   ITER            : restoring iterations per division
//   LATENCY         : clock edges from the accepting edge to the edge that samples done=1
//   abs_dvd/abs_dvs : two's-complement magnitude helpers (full-width unsigned result)
package div_pkg;

    localparam int DIV_W   = 8;
    localparam int DVD_W   = 16;
    localparam int ITER    = 8;
    localparam int LATENCY = 10;
    localparam int CNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Magnitude as an unsigned value of the same width; 16'h8000 -> 16'h8000.
    function automatic logic [DVD_W-1:0] abs_dvd(input logic [DVD_W-1:0] v);
        return v[DVD_W-1] ? (~v + {{(DVD_W-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [DIV_W-1:0] abs_dvs(input logic [DIV_W-1:0] v);
        return v[DIV_W-1] ? (~v + {{(DIV_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step -- one restoring shift/subtract iteration (purely combinational).
//   pr_i  : shifted partial remainder {rem, next dividend bit}, 9 bits
//   dvs_i : divisor magnitude, 8 bits
//   pr_o  : next partial remainder, 8 bits
//   q_o   : quotient bit produced by this iteration
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W:0]   pr_i,
    input  logic [DIV_W-1:0] dvs_i,
    output logic [DIV_W-1:0] pr_o,
    output logic             q_o
);

    // When the subtraction is taken the true difference is < dvs_i, so the
    // low 8 bits of a modular 8-bit subtract are exact.
    assign q_o  = (pr_i >= {1'b0, dvs_i});
    assign pr_o = q_o ? (pr_i[DIV_W-1:0] - dvs_i) : pr_i[DIV_W-1:0];

endmodule

// File: rtl/signed_div_16by8.sv
// signed_div_16by8 -- multi-cycle signed 16/8 divider, fixed latency.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : request; sampled only while ready=1
//   dividend     : 16-bit two's-complement dividend, captured on accept
//   divisor      : 8-bit two's-complement divisor, captured on accept
//   ready        : able to accept start (IDLE, and the DONE cycle)
//   done         : one-cycle pulse, results valid from this cycle on
//   quotient     : 8-bit two's-complement quotient (truncated toward zero)
//   remainder    : 8-bit two's-complement remainder (sign of dividend)
//   div_by_zero  : divisor was zero; quotient/remainder forced to 0
//   overflow     : quotient outside -128..127; quotient/remainder forced to 0
//   dbg_state    : current controller state
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1. Accepting edge -> CALC (8 edges) -> FIX (1 edge) -> DONE, so done
// is high during the 10th clock cycle and is seen high by the 10th edge after
// acceptance; that edge may itself accept the next request.
module signed_div_16by8
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output state_e           dbg_state
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DIV_W-1:0] rem_q;      // partial remainder
    logic [DIV_W-1:0] sh_q;       // low dividend bits in, quotient bits out
    logic [DIV_W-1:0] dvs_mag_q;
    logic             neg_q_q;    // operand signs differ
    logic             neg_r_q;    // dividend negative
    logic             dbz_q;
    logic             hi_ovf_q;   // unsigned quotient would need > 8 bits
    logic             ready_q;
    logic             done_q;
    logic [DIV_W-1:0] quo_q;
    logic [DIV_W-1:0] rmd_q;
    logic             dbz_flag_q;
    logic             ovf_flag_q;

    logic             accept;
    logic [DVD_W-1:0] dvd_mag;
    logic [DIV_W-1:0] dvs_mag;
    logic [DIV_W-1:0] step_rem;
    logic             step_q;
    logic [DIV_W-1:0] fix_q;
    logic [DIV_W-1:0] fix_r;
    logic             fix_dbz;
    logic             fix_ovf;

    assign accept  = ready_q & start;
    assign dvd_mag = abs_dvd(dividend);
    assign dvs_mag = abs_dvs(divisor);

    // Single shared iteration datapath, reused for all ITER cycles of CALC.
    div_step u_step (
        .pr_i  ({rem_q, sh_q[DIV_W-1]}),
        .dvs_i (dvs_mag_q),
        .pr_o  (step_rem),
        .q_o   (step_q)
    );

    // Sign application and range check on the unsigned result.
    // Negative results may reach magnitude 128, positive ones only 127.
    always_comb begin
        fix_q   = '0;
        fix_r   = '0;
        fix_dbz = 1'b0;
        fix_ovf = 1'b0;
        if (dbz_q) begin
            fix_dbz = 1'b1;
        end else if (hi_ovf_q || (neg_q_q ? (sh_q > 8'd128) : sh_q[DIV_W-1])) begin
            fix_ovf = 1'b1;
        end else begin
            fix_q = neg_q_q ? (~sh_q + 8'd1) : sh_q;
            fix_r = neg_r_q ? (~rem_q + 8'd1) : rem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            sh_q       <= '0;
            dvs_mag_q  <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            dbz_q      <= 1'b0;
            hi_ovf_q   <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            quo_q      <= '0;
            rmd_q      <= '0;
            dbz_flag_q <= 1'b0;
            ovf_flag_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q    <= CALC;
                        cnt_q      <= '0;
                        rem_q      <= dvd_mag[DVD_W-1:DIV_W];
                        sh_q       <= dvd_mag[DIV_W-1:0];
                        dvs_mag_q  <= dvs_mag;
                        neg_q_q    <= dividend[DVD_W-1] ^ divisor[DIV_W-1];
                        neg_r_q    <= dividend[DVD_W-1];
                        dbz_q      <= (divisor == '0);
                        // Upper dividend byte >= divisor means quotient >= 256.
                        hi_ovf_q   <= (dvd_mag[DVD_W-1:DIV_W] >= dvs_mag);
                        ready_q    <= 1'b0;
                        dbz_flag_q <= 1'b0;
                        ovf_flag_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    sh_q  <= {sh_q[DIV_W-2:0], step_q};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quo_q      <= fix_q;
                    rmd_q      <= fix_r;
                    dbz_flag_q <= fix_dbz;
                    ovf_flag_q <= fix_ovf;
                    done_q     <= 1'b1;
                    ready_q    <= 1'b1;
                    state_q    <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_flag_q;
    assign overflow    = ovf_flag_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_signed_div_16by8.sv
// Testbench for signed_div_16by8: directed vector table, handshake and reset
// sequences, and a signed product sweep. Inputs change and outputs are
// sampled on the falling edge.
module tb_signed_div_16by8;
    import div_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        ready;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;
    state_e      dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    signed_div_16by8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] eq, input logic [7:0] er,
                                input logic edbz, input logic eovf);
        check({tag, " quotient"},    16'(quotient),    16'(eq));
        check({tag, " remainder"},   16'(remainder),   16'(er));
        check({tag, " div_by_zero"}, 16'(div_by_zero), 16'(edbz));
        check({tag, " overflow"},    16'(overflow),    16'(eovf));
    endtask

    // One full operation. done must be seen high by edge LATENCY after the
    // accepting edge, i.e. at the falling edge following edge LATENCY-1.
    // Operands are scrambled after acceptance; with poke=1 start is also
    // pulsed mid-CALC with other operands, which must be ignored.
    task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input logic eovf, input bit poke);
        @(negedge clk);
        check({tag, " ready idle"}, 16'(ready), 16'd1);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        check({tag, " flags clear"}, {14'd0, div_by_zero, overflow}, 16'd0);
        for (int e = 1; e < LATENCY; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (poke && e == 3) begin
                start    = 1'b1;
                dividend = 16'h7FFF;
                divisor  = 8'h01;
            end else begin
                start = 1'b0;
            end
            if (e < LATENCY - 1) begin
                check({tag, " busy done"},  16'(done),  16'd0);
                check({tag, " busy ready"}, 16'(ready), 16'd0);
            end else begin
                check({tag, " done"},  16'(done),  16'd1);
                check({tag, " ready"}, 16'(ready), 16'd1);
                check({tag, " state"}, 16'(dbg_state), 16'(DONE));
                check_result(tag, eq, er, edbz, eovf);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, " done pulse"}, 16'(done), 16'd0);
        check_result({tag, " hold"}, eq, er, edbz, eovf);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
    } vec_t;

    vec_t vecs[20];

    initial begin
        vecs[0]  = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0}; //  100 /  7
        vecs[1]  = '{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0}; // -100 /  7
        vecs[2]  = '{16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0}; //  100 / -7
        vecs[3]  = '{16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0}; // -100 / -7
        vecs[4]  = '{16'h4000, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0}; // 16384/-128 = -128
        vecs[5]  = '{16'hC000, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1}; // = +128
        vecs[6]  = '{16'h8000, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1}; // = +32768
        vecs[7]  = '{16'h1234, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0}; // /0
        vecs[8]  = '{16'h007F, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0}; // 127
        vecs[9]  = '{16'h0080, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1}; // 128
        vecs[10] = '{16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0}; // -128
        vecs[11] = '{16'hFF7F, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1}; // -129
        vecs[12] = '{16'h7FFF, 8'h7F, 8'h00, 8'h00, 1'b0, 1'b1}; // 258
        vecs[13] = '{16'h0000, 8'h85, 8'h00, 8'h00, 1'b0, 1'b0}; // 0 / -123
        vecs[14] = '{16'h03E8, 8'hD6, 8'hE9, 8'h22, 1'b0, 1'b0}; // 1000/-42 = -23 r 34
        vecs[15] = '{16'hFC18, 8'h2A, 8'hE9, 8'hDE, 1'b0, 1'b0}; // -1000/42 = -23 r -34
        vecs[16] = '{16'h3F80, 8'h7F, 8'h00, 8'h00, 1'b0, 1'b1}; // 16256/127 = 128
        vecs[17] = '{16'hC080, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0}; // -16256/127 = -128
        vecs[18] = '{16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0}; // 255/16
        vecs[19] = '{16'h8000, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1}; // 256
    end

    // ---------------- main sequence ----------------
    initial begin
        int bl[10];
        int av[3];
        bl = '{1, -1, 2, -2, 3, 7, -9, 64, 127, -128};
        av = '{127, -128, -1};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", 16'(ready), 16'd1);
        check("reset done",  16'(done),  16'd0);
        check("reset state", 16'(dbg_state), 16'(IDLE));
        check_result("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs,
                   vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf, 1'b0);
        end

        // Start pulsed during CALC is ignored.
        run_op("poke", 16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b1);

        // start held high: second request accepted in the done cycle,
        // results every LATENCY edges.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'h0064;
        divisor  = 8'h07;
        @(posedge clk);
        for (int e = 1; e < 2 * LATENCY; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == LATENCY - 1) begin
                check("b2b done A", 16'(done), 16'd1);
                check_result("b2b A", 8'h0E, 8'h02, 1'b0, 1'b0);
                dividend = 16'hFC18;
                divisor  = 8'h2A;
            end else if (e == 2 * LATENCY - 1) begin
                check("b2b done B", 16'(done), 16'd1);
                check_result("b2b B", 8'hE9, 8'hDE, 1'b0, 1'b0);
                start = 1'b0;
            end else begin
                check("b2b no done", 16'(done), 16'd0);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("b2b idle ready", 16'(ready), 16'd1);

        // Reset during iteration 4: edges 1..3 iterate, edge 4 sees rst_n=0.
        run_op("pre rst", 16'h03E8, 8'hD6, 8'hE9, 8'h22, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'h0064;
        divisor  = 8'h07;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid rst ready", 16'(ready), 16'd1);
        check("mid rst done",  16'(done),  16'd0);
        check("mid rst state", 16'(dbg_state), 16'(IDLE));
        check_result("mid rst", 8'h00, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("post rst no done", 16'(done), 16'd0);
        end
        run_op("after rst", 16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 1'b0);

        // Signed product sweep: (a*b)/b must return a with zero remainder.
        for (int j = 0; j < 10; j++) begin
            for (int a = -128; a < 128; a++) begin
                run_op($sformatf("sweep a=%0d b=%0d", a, bl[j]), 16'(a * bl[j]), 8'(bl[j]),
                       8'(a), 8'h00, 1'b0, 1'b0, 1'b0);
            end
        end
        for (int j = 0; j < 3; j++) begin
            for (int b = -128; b < 128; b++) begin
                if (b != 0) begin
                    run_op($sformatf("sweep a=%0d b=%0d", av[j], b), 16'(av[j] * b), 8'(b),
                           8'(av[j]), 8'h00, 1'b0, 1'b0, 1'b0);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/signed_div_16by8.md
SIGNED_DIV_16BY8 -- requirements
Module: signed_div_16by8

Interface
- No parameters; all widths are fixed.
- REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-002 SHALL have port rst_n, input, 1 bit: reset is synchronous and active-low.
- REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only while ready=1.
- REQ-004 SHALL have port dividend, input, 16 bits: two's-complement dividend, captured on the accepting edge.
- REQ-005 SHALL have port divisor, input, 8 bits: two's-complement divisor, captured on the accepting edge.
- REQ-006 SHALL have port ready, output, 1 bit: 1 when idle and able to accept start.
- REQ-007 SHALL have port done, output, 1 bit: single-cycle pulse when results become valid.
- REQ-008 SHALL have port quotient, output, 8 bits: two's-complement quotient.
- REQ-009 SHALL have port remainder, output, 8 bits: two's-complement remainder.
- REQ-010 SHALL have port div_by_zero, output, 1 bit: error flag, valid with done.
- REQ-011 SHALL have port overflow, output, 1 bit: error flag, quotient outside -128..127, valid with done.

Function
- REQ-012 SHALL implement a four-state FSM:
  - IDLE --(start)--> CALC
  - CALC --(8 iterations)--> FIX
  - FIX --> DONE
  - DONE --> IDLE
- REQ-013 SHALL accept start only in IDLE, i.e. when ready=1; start in any other state is ignored without side effects.
- REQ-014 SHALL deassert ready on the cycle after acceptance and reassert it in the cycle done is high.
- REQ-015 SHALL have fixed latency for every operand pair, including error cases: done is high exactly 10 clock edges after the accepting edge.
- REQ-016 SHALL work on magnitudes in CALC: |dividend| is 16-bit unsigned, |divisor| is 8-bit unsigned; one restoring shift/subtract iteration per cycle, MSB first.
- REQ-017 SHALL apply signs in FIX:
  - quotient truncates toward zero and is negated when the operand signs differ;
  - remainder takes the sign of the dividend;
  - the identity dividend = quotient*divisor + remainder holds with |remainder| < |divisor|.
- REQ-018 SHALL set overflow=1 and drive quotient=8'h00, remainder=8'h00 when the true quotient is >127 or <-128.
  - This includes dividend=16'h8000 with divisor=8'hFF.
- REQ-019 SHALL set div_by_zero=1, overflow=0, quotient=8'h00 and remainder=8'h00 when divisor=8'h00.
- REQ-020 SHALL hold quotient, remainder and both flags stable from done until the next accepted start.
- REQ-021 SHALL clear both flags on the accepting edge.
- REQ-022 SHALL NOT allow operand input changes after acceptance to affect the result in progress.
- REQ-023 SHALL accept a start asserted in the cycle done is high: back-to-back operations with no idle bubble.

Reset
- REQ-024 SHALL, when rst_n=0 at a clock edge:
  - force state IDLE;
  - drive ready=1 and done=0;
  - drive quotient, remainder, div_by_zero and overflow to 0;
  - clear all internal registers.
- REQ-025 SHALL abandon an operation interrupted by reset mid-CALC/FIX with no done pulse; the first start after rst_n returns high behaves as from power-up.

Structure
- REQ-026 SHALL place the state enum (IDLE, CALC, FIX, DONE) and constants DIV_W=8, DVD_W=16, ITER=8 and LATENCY=10 in shared package div_pkg.
- REQ-027 SHALL isolate one restoring iteration as combinational sub-module div_step.
  - Inputs: partial remainder, divisor magnitude.
  - Outputs: next partial remainder, quotient bit.
- REQ-028 SHALL instantiate div_step once and reuse it across iterations.
- REQ-029 SHALL keep top-level RTL within 120-400 lines, excluding the package.

Verification
- REQ-030 SHALL cover signed cases:
  - 16'h0064 / 8'h07 -> quotient 8'h0E, remainder 8'h02;
  - 16'hFF9C / 8'h07 -> 8'hF2, 8'hFE;
  - 16'h0064 / 8'hF9 -> 8'hF2, 8'h02.
- REQ-031 SHALL cover range limits:
  - 16'h4000 / 8'h80 -> quotient 8'h80, remainder 8'h00, overflow=0;
  - 16'hC000 / 8'h80 -> overflow=1, quotient 8'h00;
  - 16'h8000 / 8'hFF -> overflow=1.
- REQ-032 SHALL cover 16'h1234 / 8'h00 -> div_by_zero=1, quotient 8'h00, remainder 8'h00, done still on edge 10.
- REQ-033 SHALL cover handshake boundaries:
  - start held high continuously -> one result every 10 edges;
  - start pulses during CALC -> ignored, result unchanged;
  - new start in the done cycle -> accepted.
- REQ-034 SHALL cover rst_n=0 during iteration 4 -> no done, outputs zero, ready=1 next cycle; the following start gives a correct result.
- REQ-035 SHALL run an exhaustive check over all signed a in -128..127 and b != 0:
  - dividend = a*b sign-extended to 16 bits, divisor = b -> quotient=a, remainder=0;
  - overflow=0 except a=-128, b=1 boundary checks pass.
